// File: rtl/ntr_resp_tx.sv
// ----------------------------------------------------------------------------
// ntr_resp_tx : NTR card-bus response transmitter (counts host command bytes,
//               then streams response bytes from a valid/ready source)
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ntr_resp_tx #(
  parameter int CMD_BYTES   = 8,
  parameter int RESP_BYTES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ntr_clk,
  input  logic       ntr_cs1,
  input  logic [7:0] resp_data,
  input  logic       resp_valid,
  output logic       resp_ready,
  output logic [7:0] dat_out,
  output logic       out_en,
  output logic       busy,
  output logic       underrun
);

  localparam int CW = $clog2(CMD_BYTES + 1);
  localparam int TW = $clog2(RESP_BYTES + 1);
  localparam logic [CW-1:0] c_cmd_last = CW'(CMD_BYTES);
  localparam logic [TW-1:0] c_tx_last  = TW'(RESP_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_TX   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_cs_sync;
  logic r_clk_d, r_cs_d;
  logic r_clk_rise, r_clk_fall, r_cs_fall, r_cs_rise;
  logic w_clk_s, w_cs_s;

  logic [CW-1:0] r_cmd_cnt, w_cmd_cnt_nxt;
  logic [TW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [7:0]    r_dat, w_dat_nxt;
  logic          r_underrun, w_underrun_nxt;
  logic          w_pop;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_cs_s  = r_cs_sync[SYNC_STAGES-1];

  // Chains preset to 1 so a reset never looks like a bus edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= '1;
      r_cs_sync  <= '1;
      r_clk_d    <= 1'b1;
      r_cs_d     <= 1'b1;
      r_clk_rise <= 1'b0;
      r_clk_fall <= 1'b0;
      r_cs_fall  <= 1'b0;
      r_cs_rise  <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ntr_clk};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], ntr_cs1};
      r_clk_d    <= w_clk_s;
      r_cs_d     <= w_cs_s;
      r_clk_rise <= w_clk_s & ~r_clk_d;
      r_clk_fall <= ~w_clk_s & r_clk_d;
      r_cs_rise  <= w_cs_s & ~r_cs_d;
      r_cs_fall  <= ~w_cs_s & r_cs_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cmd_cnt  <= '0;
      r_tx_cnt   <= '0;
      r_dat      <= 8'hFF;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd_cnt  <= w_cmd_cnt_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_dat      <= w_dat_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  // A chip-select release wins over a coincident ntr_clk edge, so no pop then.
  assign w_pop = r_clk_fall & ~r_cs_rise & (r_state == S_TX) & (r_tx_cnt < c_tx_last);

  always_comb begin
    w_state_nxt    = r_state;
    w_cmd_cnt_nxt  = r_cmd_cnt;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_dat_nxt      = r_dat;
    w_underrun_nxt = r_underrun;
    case (r_state)
      S_IDLE: begin
        w_dat_nxt = 8'hFF;
        if (r_cs_fall) begin
          w_state_nxt    = S_CMD;
          w_cmd_cnt_nxt  = '0;
          w_underrun_nxt = 1'b0;
        end
      end
      S_CMD: begin
        if (r_cs_rise) begin
          w_state_nxt = S_IDLE;
          w_dat_nxt   = 8'hFF;
        end else if (r_clk_rise && (r_cmd_cnt != c_cmd_last)) begin
          w_cmd_cnt_nxt = r_cmd_cnt + CW'(1);
          if (r_cmd_cnt + CW'(1) == c_cmd_last) begin
            w_state_nxt  = S_TX;
            w_tx_cnt_nxt = '0;
          end
        end
      end
      S_TX: begin
        if (r_cs_rise) begin
          w_state_nxt = S_IDLE;
          w_dat_nxt   = 8'hFF;
        end else if (w_pop) begin
          w_tx_cnt_nxt = r_tx_cnt + TW'(1);
          if (resp_valid) begin
            w_dat_nxt = resp_data;
          end else begin
            w_dat_nxt      = 8'hFF;
            w_underrun_nxt = 1'b1;
          end
        end else if (r_clk_rise && (r_tx_cnt == c_tx_last)) begin
          w_state_nxt = S_DONE;
          w_dat_nxt   = 8'hFF;
        end
      end
      S_DONE: begin
        w_dat_nxt = 8'hFF;
        if (r_cs_rise) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_dat_nxt   = 8'hFF;
      end
    endcase
  end

  assign resp_ready = w_pop;
  assign dat_out    = r_dat;
  assign out_en     = (r_state == S_TX);
  assign busy       = (r_state != S_IDLE);
  assign underrun   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_ntr_resp_tx.sv
// ----------------------------------------------------------------------------
// tb_ntr_resp_tx : directed bench with a host-sample scoreboard for ntr_resp_tx
// Revision       : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ntr_resp_tx;

  localparam int PH = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic       ntr_clk;
  logic       ntr_cs1;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] dat_out;
  logic       out_en;
  logic       busy;
  logic       underrun;

  always #5 clk = ~clk;

  ntr_resp_tx #(.CMD_BYTES(8), .RESP_BYTES(4), .SYNC_STAGES(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .ntr_clk    (ntr_clk),
    .ntr_cs1    (ntr_cs1),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .dat_out    (dat_out),
    .out_en     (out_en),
    .busy       (busy),
    .underrun   (underrun)
  );

  logic [7:0] src_data [0:7];
  logic       src_vld  [0:7];
  logic [2:0] src_idx;
  logic       rdy_d;
  int         pop_cnt;
  logic       oe_seen;
  logic [7:0] exp_q [$];
  int         n_chk;
  int         n_fail;

  assign resp_data  = src_data[src_idx];
  assign resp_valid = src_vld[src_idx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source advances half a cycle after the load edge that consumed its byte.
  always @(negedge clk) begin
    if (rdy_d) src_idx = src_idx + 3'd1;
    rdy_d = resp_ready;
    if (resp_ready === 1'b1) pop_cnt++;
    if (out_en === 1'b1) oe_seen = 1'b1;
  end

  // Host samples ntr_data on every ntr_clk rise while the card drives it.
  always @(posedge ntr_clk) begin
    if (out_en === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_sample_out_en", 32'(out_en), 32'd0);
      else chk("host_sample", 32'(dat_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic setup(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [7:0] d3, input logic v2);
    for (int i = 0; i < 8; i++) begin
      src_data[i] = 8'h00;
      src_vld[i]  = 1'b0;
    end
    src_data[0] = d0; src_vld[0] = 1'b1;
    src_data[1] = d1; src_vld[1] = 1'b1;
    src_data[2] = d2; src_vld[2] = v2;
    src_data[3] = d3; src_vld[3] = 1'b1;
    src_idx = 3'd0;
    pop_cnt = 0;
    oe_seen = 1'b0;
  endtask

  task automatic cs_low();
    ntr_cs1 = 1'b0;
    #PH;
  endtask

  task automatic cs_high();
    ntr_cs1 = 1'b1;
    #PH;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      ntr_clk = 1'b0;
      #PH;
      ntr_clk = 1'b1;
      #PH;
    end
  endtask

  task automatic nominal(input string tag);
    setup(8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    cs_low();
    chk({tag, "_underrun_clr"}, 32'(underrun), 32'd0);
    pulse(8);
    chk({tag, "_oe_after_cmd"}, 32'(out_en), 32'd1);
    chk({tag, "_dat_before_load"}, 32'(dat_out), 32'hFF);
    pulse(4);
    chk({tag, "_done_oe"}, 32'(out_en), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd1);
    cs_high();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pops"}, 32'(pop_cnt), 32'd4);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rdy_d   = 1'b0;
    rst     = 1'b1;
    ntr_clk = 1'b1;
    ntr_cs1 = 1'b1;
    setup(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_dat_out", 32'(dat_out), 32'hFF);
    chk("rst_out_en", 32'(out_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_resp_ready", 32'(resp_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    #PH;

    nominal("s1");

    // Underrun on the third byte
    setup(8'hA0, 8'hA1, 8'h55, 8'hA3, 1'b0);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hA3);
    cs_low();
    pulse(12);
    chk("s2_underrun_set", 32'(underrun), 32'd1);
    cs_high();
    chk("s2_underrun_hold", 32'(underrun), 32'd1);
    chk("s2_pops", 32'(pop_cnt), 32'd4);
    chk("s2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Early abort after two response bytes
    setup(8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    cs_low();
    chk("s3_underrun_clr", 32'(underrun), 32'd0);
    pulse(10);
    ntr_cs1 = 1'b1;
    #40;
    chk("s3_abort_oe", 32'(out_en), 32'd0);
    chk("s3_abort_busy", 32'(busy), 32'd0);
    #PH;
    chk("s3_pops", 32'(pop_cnt), 32'd2);
    chk("s3_queue_empty", 32'(exp_q.size()), 32'd0);
    nominal("s3r");

    // Short command
    setup(8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1);
    cs_low();
    pulse(5);
    cs_high();
    chk("s4_oe_never", 32'(oe_seen), 32'd0);
    chk("s4_pops", 32'(pop_cnt), 32'd0);
    chk("s4_busy", 32'(busy), 32'd0);

    // Extra clocks after the last response byte
    setup(8'hB0, 8'hB1, 8'hB2, 8'hB3, 1'b1);
    exp_q.push_back(8'hB0); exp_q.push_back(8'hB1);
    exp_q.push_back(8'hB2); exp_q.push_back(8'hB3);
    cs_low();
    pulse(15);
    chk("s5_oe", 32'(out_en), 32'd0);
    chk("s5_dat", 32'(dat_out), 32'hFF);
    chk("s5_busy", 32'(busy), 32'd1);
    chk("s5_pops", 32'(pop_cnt), 32'd4);
    cs_high();
    chk("s5_idle_busy", 32'(busy), 32'd0);
    chk("s5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-TX
    setup(8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    cs_low();
    pulse(10);
    chk("s6_pre_oe", 32'(out_en), 32'd1);
    chk("s6_pre_dat", 32'(dat_out), 32'hA1);
    rst = 1'b1;
    ntr_cs1 = 1'b1;
    #1;
    chk("s6_rst_oe", 32'(out_en), 32'd0);
    chk("s6_rst_dat", 32'(dat_out), 32'hFF);
    chk("s6_rst_busy", 32'(busy), 32'd0);
    #30;
    rst = 1'b0;
    @(posedge clk);
    #2;
    #PH;
    nominal("s6r");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
